// File: rtl/reaction_ms_counter_pkg.sv
// Shared encodings for the reaction-time millisecond counter.
// Covers the flag values from the main control logic, the state set and the BCD geometry.
package reaction_ms_counter_pkg;

  localparam logic [1:0] CF_CLEAR = 2'b00;
  localparam logic [1:0] CF_STOP  = 2'b01;
  localparam logic [1:0] CF_START = 2'b10;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 4;
  localparam int BCD_W       = BCD_DIGIT_W * BCD_DIGITS;

  localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/reaction_ms_counter_if.sv
// Bundle between the main control logic (master) and the ms counter (slave).
// The display driver also taps the result signals carried here.
interface reaction_ms_counter_if;
  import reaction_ms_counter_pkg::*;

  logic [1:0]       counter_flag;
  logic             error_flag;
  logic [BCD_W-1:0] count_bcd;
  logic             running;
  logic             result_valid;
  logic             overflow;
  logic [BCD_W-1:0] best_bcd;
  logic             best_valid;

  modport master (
    output counter_flag, error_flag,
    input  count_bcd, running, result_valid, overflow, best_bcd, best_valid
  );

  modport slave (
    input  counter_flag, error_flag,
    output count_bcd, running, result_valid, overflow, best_bcd, best_valid
  );

endinterface

// File: rtl/reaction_ms_counter_bcd_digit_counter.sv
// One decimal decade: counts 0..9 on en, zeroes synchronously on clr.
// co is high when this decade wraps, so decades chain into a ripple counter.
module reaction_ms_counter_bcd_digit_counter
  import reaction_ms_counter_pkg::*;
(
  input  logic                   clk_50M,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   co
);

  logic [BCD_DIGIT_W-1:0] digit_d, digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (en) begin
      digit_d = (digit_q == BCD_DIGIT_W'(9)) ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign co    = en && (digit_q == BCD_DIGIT_W'(9));

endmodule

// File: rtl/reaction_ms_counter.sv
// Reaction-time counter: counts ms in BCD while RUN, holds on stop, and keeps
// the shortest error-free, non-saturated result until reset.
module reaction_ms_counter
  import reaction_ms_counter_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000
) (
  input  logic                  clk_50M,
  input  logic                  rst_n,
  reaction_ms_counter_if.slave  bus
);

  localparam int               TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             overflow_q, overflow_d;
  logic [BCD_W-1:0] best_q, best_d;
  logic             best_valid_q, best_valid_d;

  logic [BCD_W-1:0]    count;
  logic [BCD_DIGITS:0] carry;
  logic                enter_run, stay_run, stop_run, clr_count, at_max, tick;
  logic                running, result_valid;
  logic                unused_carry;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.counter_flag == CF_START)     state_d = ST_RUN;
        else if (bus.counter_flag == CF_STOP) state_d = ST_HOLD;
      end
      ST_RUN: begin
        if (bus.counter_flag == CF_STOP)       state_d = ST_HOLD;
        else if (bus.counter_flag == CF_CLEAR) state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (bus.counter_flag == CF_START)      state_d = ST_RUN;
        else if (bus.counter_flag == CF_CLEAR) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    running      = (state_q == ST_RUN);
    result_valid = (state_q == ST_HOLD);
  end

  // A tick on the stop edge is discarded because stay_run is low there.
  always_comb begin
    enter_run = (state_d == ST_RUN) && (state_q != ST_RUN);
    stay_run  = (state_d == ST_RUN) && (state_q == ST_RUN);
    stop_run  = (state_d == ST_HOLD) && (state_q == ST_RUN);
    clr_count = enter_run || (state_d == ST_IDLE);
    at_max    = (count == BCD_MAX);
    tick      = stay_run && !overflow_q && (presc_q == PRE_LAST);

    presc_d    = presc_q;
    overflow_d = overflow_q;
    if (clr_count) begin
      presc_d    = '0;
      overflow_d = 1'b0;
    end else if (stay_run && !overflow_q) begin
      if (presc_q == PRE_LAST) begin
        if (at_max) overflow_d = 1'b1;
        else        presc_d    = '0;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // BCD digits order the same way as plain binary, so a 16-bit compare suffices.
    best_d       = best_q;
    best_valid_d = best_valid_q;
    if (stop_run && !bus.error_flag && !overflow_q &&
        (!best_valid_q || (count < best_q))) begin
      best_d       = count;
      best_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      overflow_q   <= 1'b0;
      best_q       <= '0;
      best_valid_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      overflow_q   <= overflow_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign carry[0] = tick && !at_max;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    reaction_ms_counter_bcd_digit_counter u_digit (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .clr     (clr_count),
      .en      (carry[i]),
      .digit   (count[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .co      (carry[i+1])
    );
  end

  // Top-level carry can never fire: saturation blocks the 9999 -> 0000 wrap.
  assign unused_carry = carry[BCD_DIGITS];

  assign bus.count_bcd    = count;
  assign bus.running      = running;
  assign bus.result_valid = result_valid;
  assign bus.overflow     = overflow_q;
  assign bus.best_bcd     = best_q;
  assign bus.best_valid   = best_valid_q;

endmodule

// File: tb/tb_reaction_ms_counter.sv
// Bench for reaction_ms_counter: scenario tasks against an integer-millisecond model.
// A small clock ratio keeps the full 9999 saturation run short.
module tb_reaction_ms_counter;
  import reaction_ms_counter_pkg::*;

  localparam int CLK_HZ  = 3;
  localparam int TICK_HZ = 1;
  localparam int D       = CLK_HZ / TICK_HZ;

  logic clk_50M = 1'b0;
  logic rst_n   = 1'b1;

  int total = 0;
  int bad   = 0;

  int m_count = 0;
  bit m_ovf   = 1'b0;
  int m_best  = 0;
  bit m_bv    = 1'b0;

  reaction_ms_counter_if bus();

  reaction_ms_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_50M = ~clk_50M;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Holds start for cyc edges (first edge enters RUN), checking every cycle.
  task automatic run_for(input int cyc);
    int ms;
    for (int e = 1; e <= cyc; e++) begin
      bus.counter_flag = (e == 1 || $urandom_range(0, 1) == 0) ? CF_START : 2'b11;
      @(negedge clk_50M);
      ms      = (e - 1) / D;
      m_ovf   = (ms >= 10000);
      m_count = (ms > 9999) ? 9999 : ms;
      total++;
      if (bus.count_bcd !== to_bcd(m_count) || bus.running !== 1'b1 ||
          bus.overflow !== m_ovf) begin
        bad++;
        $display("FAIL run_cycle e=%0d: count=%h running=%b ovf=%b, expected count=%h running=1 ovf=%b",
                 e, bus.count_bcd, bus.running, bus.overflow, to_bcd(m_count), m_ovf);
      end
    end
  endtask

  task automatic stop_trial(input bit err);
    bus.counter_flag = CF_STOP;
    bus.error_flag   = err;
    @(negedge clk_50M);
    if (!err && !m_ovf && (!m_bv || m_count < m_best)) begin
      m_best = m_count;
      m_bv   = 1'b1;
    end
    total++;
    if (bus.count_bcd !== to_bcd(m_count) || bus.result_valid !== 1'b1 ||
        bus.running !== 1'b0 || bus.overflow !== m_ovf) begin
      bad++;
      $display("FAIL stop_hold: count=%h rv=%b run=%b ovf=%b, expected count=%h rv=1 run=0 ovf=%b",
               bus.count_bcd, bus.result_valid, bus.running, bus.overflow, to_bcd(m_count), m_ovf);
    end
    total++;
    if (bus.best_bcd !== to_bcd(m_best) || bus.best_valid !== m_bv) begin
      bad++;
      $display("FAIL stop_best: best=%h bv=%b, expected best=%h bv=%b",
               bus.best_bcd, bus.best_valid, to_bcd(m_best), m_bv);
    end
    bus.error_flag = 1'b0;
    repeat ($urandom_range(1, 4)) begin
      bus.counter_flag = ($urandom_range(0, 1) == 0) ? CF_STOP : 2'b11;
      @(negedge clk_50M);
      total++;
      if (bus.count_bcd !== to_bcd(m_count) || bus.result_valid !== 1'b1) begin
        bad++;
        $display("FAIL hold_stays: count=%h rv=%b, expected count=%h rv=1",
                 bus.count_bcd, bus.result_valid, to_bcd(m_count));
      end
    end
  endtask

  task automatic clear_to_idle();
    bus.counter_flag = CF_CLEAR;
    @(negedge clk_50M);
    m_count = 0;
    m_ovf   = 1'b0;
    total++;
    if (bus.count_bcd !== 16'h0000 || bus.running !== 1'b0 || bus.result_valid !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.best_bcd !== to_bcd(m_best) || bus.best_valid !== m_bv) begin
      bad++;
      $display("FAIL clear_idle: count=%h run=%b rv=%b ovf=%b best=%h bv=%b, expected 0000 0 0 0 %h %b",
               bus.count_bcd, bus.running, bus.result_valid, bus.overflow,
               bus.best_bcd, bus.best_valid, to_bcd(m_best), m_bv);
    end
  endtask

  task automatic test_reset();
    bus.counter_flag = CF_START;
    bus.error_flag   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.count_bcd !== 16'h0 || bus.running !== 1'b0 || bus.result_valid !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.best_bcd !== 16'h0 || bus.best_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: count=%h run=%b rv=%b ovf=%b best=%h bv=%b, expected all 0",
               bus.count_bcd, bus.running, bus.result_valid, bus.overflow, bus.best_bcd, bus.best_valid);
    end
    repeat (2) @(negedge clk_50M);
    total++;
    if (bus.running !== 1'b0 || bus.count_bcd !== 16'h0) begin
      bad++;
      $display("FAIL reset_held: run=%b count=%h, expected 0 0000", bus.running, bus.count_bcd);
    end
    rst_n = 1'b1;
    @(negedge clk_50M);
    total++;
    if (bus.running !== 1'b1 || bus.count_bcd !== 16'h0 || bus.result_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_run: run=%b count=%h rv=%b, expected 1 0000 0",
               bus.running, bus.count_bcd, bus.result_valid);
    end
    clear_to_idle();
  endtask

  task automatic test_first_trial();
    run_for(237 * D + 1);
    stop_trial(1'b0);
    total++;
    if (bus.count_bcd !== 16'h0237 || bus.best_bcd !== 16'h0237 || bus.best_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_trial: count=%h best=%h bv=%b, expected 0237 0237 1",
               bus.count_bcd, bus.best_bcd, bus.best_valid);
    end
  endtask

  task automatic test_back_to_back();
    run_for(150 * D + 1);
    stop_trial(1'b0);
    run_for(300 * D + 1);
    stop_trial(1'b0);
    total++;
    if (bus.count_bcd !== 16'h0300 || bus.best_bcd !== 16'h0150) begin
      bad++;
      $display("FAIL back_to_back: count=%h best=%h, expected 0300 0150", bus.count_bcd, bus.best_bcd);
    end
  endtask

  task automatic test_error_stop();
    run_for(50 * D + 1);
    stop_trial(1'b1);
    total++;
    if (bus.count_bcd !== 16'h0050 || bus.best_bcd !== 16'h0150) begin
      bad++;
      $display("FAIL error_stop: count=%h best=%h, expected 0050 0150", bus.count_bcd, bus.best_bcd);
    end
  endtask

  task automatic test_overflow();
    run_for(10005 * D + 1);
    stop_trial(1'b0);
    total++;
    if (bus.count_bcd !== 16'h9999 || bus.overflow !== 1'b1 || bus.best_bcd !== 16'h0150) begin
      bad++;
      $display("FAIL overflow_hold: count=%h ovf=%b best=%h, expected 9999 1 0150",
               bus.count_bcd, bus.overflow, bus.best_bcd);
    end
    run_for(1);
    clear_to_idle();
  endtask

  task automatic test_idle_to_hold();
    bus.counter_flag = CF_STOP;
    bus.error_flag   = 1'b0;
    @(negedge clk_50M);
    total++;
    if (bus.result_valid !== 1'b1 || bus.count_bcd !== 16'h0 ||
        bus.best_bcd !== to_bcd(m_best) || bus.best_valid !== m_bv) begin
      bad++;
      $display("FAIL idle_to_hold: rv=%b count=%h best=%h bv=%b, expected 1 0000 %h %b",
               bus.result_valid, bus.count_bcd, bus.best_bcd, bus.best_valid, to_bcd(m_best), m_bv);
    end
    clear_to_idle();
  endtask

  task automatic test_clear_mid_run();
    run_for(42 * D + 1);
    clear_to_idle();
  endtask

  task automatic test_random_trials();
    for (int t = 0; t < 12; t++) begin
      run_for($urandom_range(0, 400) * D + 1 + $urandom_range(0, D - 1));
      stop_trial($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) clear_to_idle();
    end
  endtask

  task automatic test_mid_reset();
    run_for(20 * D + 1);
    #2 rst_n = 1'b0;
    #1;
    m_best  = 0;
    m_bv    = 1'b0;
    m_count = 0;
    m_ovf   = 1'b0;
    total++;
    if (bus.best_valid !== 1'b0 || bus.best_bcd !== 16'h0 || bus.count_bcd !== 16'h0 ||
        bus.running !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: bv=%b best=%h count=%h run=%b, expected 0 0000 0000 0",
               bus.best_valid, bus.best_bcd, bus.count_bcd, bus.running);
    end
    bus.counter_flag = CF_CLEAR;
    @(negedge clk_50M);
    rst_n = 1'b1;
    clear_to_idle();
  endtask

  initial begin
    test_reset();
    test_first_trial();
    test_back_to_back();
    test_error_stop();
    test_overflow();
    test_idle_to_hold();
    test_clear_mid_run();
    test_random_trials();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
